// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift request scheduler.
package lift_pkg;

  localparam int FLOOR_W    = 7;
  localparam int MAX_FLOORS = 1 << FLOOR_W;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DWELL = 2'd2
  } sched_state_t;

  // Number of set bits in a bitmap padded out to the full floor space.
  function automatic logic [7:0] popcount(input logic [MAX_FLOORS-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/lift_pend_search.sv
// Combinational nearest-pending-floor search in one direction.
// dir_up = 1 looks for the lowest pending floor above cur_floor,
// dir_up = 0 for the highest pending floor below it. incl_cur lets the
// current floor itself qualify.
module lift_pend_search
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 64
) (
  input  logic [NUM_FLOORS-1:0] pend,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  dir_up,
  input  logic                  incl_cur,
  output logic                  found,
  output logic [FLOOR_W-1:0]    found_floor
);

  logic   up_found;
  floor_t up_floor;
  logic   dn_found;
  floor_t dn_floor;

  // Scan both directions; the last qualifying hit of each loop is the nearest.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch can be inferred.
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    // NOTE: blocking assignments here so later loop iterations see earlier ones.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend[i] && ((floor_t'(i) > cur_floor) ||
                      (incl_cur && (floor_t'(i) == cur_floor)))) begin
        up_found = 1'b1;
        up_floor = floor_t'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] && ((floor_t'(i) < cur_floor) ||
                      (incl_cur && (floor_t'(i) == cur_floor)))) begin
        dn_found = 1'b1;
        dn_floor = floor_t'(i);
      end
    end
  end

  assign found       = dir_up ? up_found : dn_found;
  assign found_floor = dir_up ? up_floor : dn_floor;

endmodule

// File: rtl/lift_req_sched.sv
// LOOK-policy request scheduler in front of the lift controller.
// Collects button presses into a pending bitmap, drives the controller's
// target floor, detects arrival and times the door dwell.
// Optional feature: define LIFT_SCHED_FLOOR_LOCK_EN to add a lock_mask
// input that blocks and clears requests for locked floors.
module lift_req_sched
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS   = 64,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_valid,
  input  logic [FLOOR_W-1:0]    btn_floor,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  stop,
  input  logic                  door,
`ifdef LIFT_SCHED_FLOOR_LOCK_EN
  input  logic [NUM_FLOORS-1:0] lock_mask,
`endif
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  req_valid,
  output logic                  dir_up,
  output logic [7:0]            pending_cnt,
  output logic                  busy
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  sched_state_t          state_q, state_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  floor_t                req_floor_q, req_floor_d;
  logic                  req_valid_q, req_valid_d;
  logic                  dir_up_q, dir_up_d;
  logic [7:0]            dwell_q, dwell_d;

  logic [NUM_FLOORS-1:0] locked;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;
  logic                  tgt_locked;
  logic                  arrive;
  logic                  incl_cur;

  logic                  ahead_found, behind_found;
  floor_t                ahead_floor, behind_floor;
  logic                  up_found, dn_found;
  floor_t                up_floor, dn_floor;
  floor_t                dist_up, dist_dn;
  logic [MAX_FLOORS-1:0] pend_ext;

`ifdef LIFT_SCHED_FLOOR_LOCK_EN
  assign locked = lock_mask;
`else
  assign locked = '0;
`endif

  assign arrive = req_valid_q && stop && door && (cur_floor == req_floor_q);

  // Decode the press and the arrival into one-hot set/clear masks; out-of-range
  // presses match no bit and are dropped here.
  always_comb begin
    set_vec    = '0;
    clr_vec    = '0;
    tgt_locked = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (btn_valid && (btn_floor == floor_t'(i))) set_vec[i] = 1'b1;
      if (arrive && (req_floor_q == floor_t'(i)))  clr_vec[i] = 1'b1;
      if (req_valid_q && (req_floor_q == floor_t'(i))) tgt_locked = locked[i];
    end
  end

  // Clear beats set, so a press to the floor being served is absorbed.
  assign pend_d = (pend_q | set_vec) & ~clr_vec & ~locked;

  // While travelling only strictly-ahead floors may retarget; otherwise the
  // current floor is a legitimate candidate.
  assign incl_cur = (state_q != SERVE);

  lift_pend_search #(.NUM_FLOORS(NUM_FLOORS)) u_ahead (
    .pend        (pend_q),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up_q),
    .incl_cur    (incl_cur),
    .found       (ahead_found),
    .found_floor (ahead_floor)
  );

  lift_pend_search #(.NUM_FLOORS(NUM_FLOORS)) u_behind (
    .pend        (pend_q),
    .cur_floor   (cur_floor),
    .dir_up      (~dir_up_q),
    .incl_cur    (incl_cur),
    .found       (behind_found),
    .found_floor (behind_floor)
  );

  // Re-express ahead/behind as up/down for the IDLE nearest-floor choice.
  always_comb begin
    up_found = dir_up_q ? ahead_found  : behind_found;
    up_floor = dir_up_q ? ahead_floor  : behind_floor;
    dn_found = dir_up_q ? behind_found : ahead_found;
    dn_floor = dir_up_q ? behind_floor : ahead_floor;
    dist_up  = up_floor - cur_floor;
    dist_dn  = cur_floor - dn_floor;
  end

  // Next-state and next-target logic.
  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    req_valid_d = req_valid_q;
    dir_up_d    = dir_up_q;
    dwell_d     = dwell_q;
    case (state_q)
      IDLE: begin
        req_valid_d = 1'b0;
        if (|pend_q) begin
          if (up_found && (!dn_found || (dist_up <= dist_dn))) begin
            req_floor_d = up_floor;
            dir_up_d    = 1'b1;
          end else begin
            req_floor_d = dn_floor;
            dir_up_d    = 1'b0;
          end
          req_valid_d = 1'b1;
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (arrive) begin
          state_d     = DWELL;
          req_valid_d = 1'b0;
          dwell_d     = DWELL_LOAD;
        end else if (tgt_locked) begin
          // Locked target: skip the dwell and re-plan on the next edge.
          state_d     = DWELL;
          req_valid_d = 1'b0;
          dwell_d     = '0;
        end else if (ahead_found &&
                     (dir_up_q ? (ahead_floor < req_floor_q)
                               : (ahead_floor > req_floor_q))) begin
          req_floor_d = ahead_floor;
        end
      end
      DWELL: begin
        if (dwell_q == '0) begin
          if (ahead_found) begin
            state_d     = SERVE;
            req_floor_d = ahead_floor;
            req_valid_d = 1'b1;
          end else if (behind_found) begin
            state_d     = SERVE;
            req_floor_d = behind_floor;
            req_valid_d = 1'b1;
            dir_up_d    = ~dir_up_q;
          end else begin
            state_d     = IDLE;
          end
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State, bitmap and output registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: the pending bitmap is plain flops, not a RAM, so it is reset like any other state.
      pend_q      <= '0;
      req_floor_q <= '0;
      req_valid_q <= 1'b0;
      dir_up_q    <= 1'b1;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      req_floor_q <= req_floor_d;
      req_valid_q <= req_valid_d;
      dir_up_q    <= dir_up_d;
      dwell_q     <= dwell_d;
    end
  end

  // Pending count derived from the registered bitmap.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[NUM_FLOORS-1:0] = pend_q;
    pending_cnt              = popcount(pend_ext);
  end

  assign req_floor = req_floor_q;
  assign req_valid = req_valid_q;
  assign dir_up    = dir_up_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lift_req_sched.sv
// Directed bench for lift_req_sched (NUM_FLOORS=64, DWELL_CYCLES=8).
module tb_lift_req_sched;

  logic       clk;
  logic       reset;
  logic       btn_valid;
  logic [6:0] btn_floor;
  logic [6:0] cur_floor;
  logic       stop;
  logic       door;
  logic [6:0] req_floor;
  logic       req_valid;
  logic       dir_up;
  logic [7:0] pending_cnt;
  logic       busy;
`ifdef LIFT_SCHED_FLOOR_LOCK_EN
  logic [63:0] lock_mask;
`endif

  int total = 0;
  int bad   = 0;

  lift_req_sched #(.NUM_FLOORS(64), .DWELL_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_valid   (btn_valid),
    .btn_floor   (btn_floor),
    .cur_floor   (cur_floor),
    .stop        (stop),
    .door        (door),
`ifdef LIFT_SCHED_FLOOR_LOCK_EN
    .lock_mask   (lock_mask),
`endif
    .req_floor   (req_floor),
    .req_valid   (req_valid),
    .dir_up      (dir_up),
    .pending_cnt (pending_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       bv;
    logic [6:0] bf;
    logic [6:0] cf;
    logic       st;
    logic       dr;
    logic [6:0] e_req;
    logic       e_val;
    logic       e_up;
    logic [7:0] e_cnt;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, input int bv, input int bf, input int cf,
                     input int st, input int dr, input int e_req, input int e_val,
                     input int e_up, input int e_cnt, input int e_busy);
    vec_t v;
    v.rst = rst[0]; v.bv = bv[0]; v.bf = bf[6:0]; v.cf = cf[6:0];
    v.st = st[0]; v.dr = dr[0];
    v.e_req = e_req[6:0]; v.e_val = e_val[0]; v.e_up = e_up[0];
    v.e_cnt = e_cnt[7:0]; v.e_busy = e_busy[0];
    vecs.push_back(v);
  endtask

  // Seven further dwell cycles with the car parked, outputs unchanged.
  task automatic add_dwell(input int cf, input int e_req, input int e_up, input int e_cnt);
    for (int k = 0; k < 7; k++) add(0, 0, 0, cf, 1, 1, e_req, 0, e_up, e_cnt, 1);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int f);
    btn_valid = 1'b1;
    btn_floor = f[6:0];
    tick();
    btn_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; btn_valid = 1'b0; btn_floor = '0; cur_floor = '0;
    stop = 1'b0; door = 1'b0;
`ifdef LIFT_SCHED_FLOOR_LOCK_EN
    lock_mask = '0;
`endif

    //  rst bv bf  cf st dr   req val up cnt busy
    add(1, 0, 0,  0, 0, 0,    0, 0, 1, 0, 0);   // reset values
    add(0, 1, 25, 0, 0, 0,    0, 0, 1, 1, 0);   // press lands in bitmap
    add(0, 0, 0,  0, 0, 0,   25, 1, 1, 1, 1);   // target after second edge
    add(0, 0, 0, 10, 0, 0,   25, 1, 1, 1, 1);   // moving up past 10
    add(0, 1, 15,10, 0, 0,   25, 1, 1, 2, 1);   // press between car and target
    add(0, 0, 0, 10, 0, 0,   15, 1, 1, 2, 1);   // retarget to 15
    add(0, 1, 5, 10, 0, 0,   15, 1, 1, 3, 1);   // press behind the car
    add(0, 0, 0, 10, 0, 0,   15, 1, 1, 3, 1);   // no retarget
    add(0, 1, 20,12, 0, 0,   15, 1, 1, 4, 1);   // press beyond the target
    add(0, 0, 0, 12, 0, 0,   15, 1, 1, 4, 1);   // no retarget
    add(0, 0, 0, 15, 1, 1,   15, 0, 1, 3, 1);   // arrive at 15
    add_dwell(15, 15, 1, 3);
    add(0, 0, 0, 15, 1, 1,   20, 1, 1, 3, 1);   // continue up to 20
    add(0, 0, 0, 20, 1, 1,   20, 0, 1, 2, 1);   // arrive at 20
    add_dwell(20, 20, 1, 2);
    add(0, 0, 0, 20, 1, 1,   25, 1, 1, 2, 1);   // continue up to 25
    add(0, 0, 0, 25, 1, 1,   25, 0, 1, 1, 1);   // arrive at 25
    add_dwell(25, 25, 1, 1);
    add(0, 0, 0, 25, 1, 1,    5, 1, 0, 1, 1);   // nothing ahead: reverse to 5
    add(0, 1, 5,  5, 1, 1,    5, 0, 0, 0, 1);   // arrive at 5 with same-floor press
    add_dwell(5, 5, 0, 0);
    add(0, 0, 0,  5, 1, 1,    5, 0, 0, 0, 0);   // nothing pending: IDLE

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      btn_valid = vecs[i].bv;
      btn_floor = vecs[i].bf;
      cur_floor = vecs[i].cf;
      stop      = vecs[i].st;
      door      = vecs[i].dr;
      tick();
      check($sformatf("v%0d req_floor", i),   32'(req_floor),   32'(vecs[i].e_req));
      check($sformatf("v%0d req_valid", i),   32'(req_valid),   32'(vecs[i].e_val));
      check($sformatf("v%0d dir_up", i),      32'(dir_up),      32'(vecs[i].e_up));
      check($sformatf("v%0d pending_cnt", i), 32'(pending_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d busy", i),        32'(busy),        32'(vecs[i].e_busy));
    end
    reset = 1'b0; btn_valid = 1'b0; stop = 1'b0; door = 1'b0; cur_floor = 7'd5;

    // Out-of-range presses, then duplicate presses.
    press(80);
    check("drop80 pending_cnt", 32'(pending_cnt), 32'd0);
    check("drop80 busy", 32'(busy), 32'd0);
    press(64);
    check("drop64 pending_cnt", 32'(pending_cnt), 32'd0);
    press(37);
    check("dup1 pending_cnt", 32'(pending_cnt), 32'd1);
    press(37);
    press(37);
    check("dup3 pending_cnt", 32'(pending_cnt), 32'd1);
    check("dup3 req_floor", 32'(req_floor), 32'd37);
    check("dup3 req_valid", 32'(req_valid), 32'd1);
    check("dup3 dir_up", 32'(dir_up), 32'd1);

    // Three more floors beyond the target, arrive, then reset mid-dwell.
    press(40);
    press(50);
    press(60);
    check("beyond pending_cnt", 32'(pending_cnt), 32'd4);
    check("beyond req_floor", 32'(req_floor), 32'd37);
    cur_floor = 7'd37; stop = 1'b1; door = 1'b1;
    tick();
    check("arr37 req_valid", 32'(req_valid), 32'd0);
    check("arr37 pending_cnt", 32'(pending_cnt), 32'd3);
    tick();
    tick();
    check("dwell37 busy", 32'(busy), 32'd1);
    check("dwell37 req_floor", 32'(req_floor), 32'd37);
    reset = 1'b1;
    press(10);
    reset = 1'b0;
    check("rst req_floor", 32'(req_floor), 32'd0);
    check("rst req_valid", 32'(req_valid), 32'd0);
    check("rst dir_up", 32'(dir_up), 32'd1);
    check("rst pending_cnt", 32'(pending_cnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    stop = 1'b0; door = 1'b0;
    tick();
    check("post_rst pending_cnt", 32'(pending_cnt), 32'd0);
    check("post_rst busy", 32'(busy), 32'd0);

`ifdef LIFT_SCHED_FLOOR_LOCK_EN
    // Lock the floor currently being served.
    cur_floor = 7'd30;
    press(37);
    tick();
    check("lk req_floor", 32'(req_floor), 32'd37);
    press(10);
    check("lk pending_cnt", 32'(pending_cnt), 32'd2);
    lock_mask[37] = 1'b1;
    tick();
    check("lk dropped pending_cnt", 32'(pending_cnt), 32'd1);
    check("lk dropped req_valid", 32'(req_valid), 32'd0);
    tick();
    check("lk next req_floor", 32'(req_floor), 32'd10);
    check("lk next req_valid", 32'(req_valid), 32'd1);
    check("lk next dir_up", 32'(dir_up), 32'd0);
    press(37);
    check("lk press dropped", 32'(pending_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
